// File: rtl/iclk_monitor.sv
// iclk_monitor: synchronizes iclk_in, strobes its edges, measures its period and tracks lock/loss; ICLK_MON_PERIOD_OUT_EN adds period_meas
module iclk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 25,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic       iclk_in,
    input  logic       lost_clr,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic       locked,
`ifdef ICLK_MON_PERIOD_OUT_EN
    output logic [6:0] period_meas,
`endif
    output logic       lost
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [6:0] TMO = 7'(TIMEOUT);
    localparam logic [6:0] LO = 7'(EXP_PERIOD - TOL);
    localparam logic [6:0] HI = 7'(EXP_PERIOD + TOL);
    localparam logic [GW-1:0] LCK = GW'(LOCK_COUNT);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q, rise_q, fall_q, locked_q, lost_q;
    logic rise_d, fall_d, in_tol;
    logic [6:0] cnt_q, cnt_d, sample_q, sample_d;
    logic [GW-1:0] good_q, good_d;
    // Edge detect, period counter (1 while rise_stb is high) and lock FSM next state
    always_comb begin
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
        cnt_d = rise_d ? 7'd1 : (cnt_q == TMO ? TMO : cnt_q + 7'd1);
        sample_d = rise_d ? cnt_q : sample_q;
        in_tol = sample_q >= LO && sample_q <= HI;
        state_d = state_q;
        good_d = good_q;
        case (state_q)
            IDLE: if (rise_q) begin
                state_d = ACQ;
                good_d = '0;
            end
            ACQ: if (cnt_d == TMO) state_d = LOST;
                else if (rise_q) begin
                    good_d = in_tol ? good_q + GW'(1) : '0;
                    if (in_tol && good_q + GW'(1) == LCK) state_d = LOCKED;
                end
            LOCKED: if (cnt_d == TMO || (rise_q && !in_tol)) state_d = LOST;
            LOST: if (lost_clr) state_d = IDLE;
        endcase
    end
    // All state, with outputs registered from the next-state decode
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q <= '0;
            sample_q <= '0;
            good_q <= '0;
            state_q <= IDLE;
            locked_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iclk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q <= cnt_d;
            sample_q <= sample_d;
            good_q <= good_d;
            state_q <= state_d;
            locked_q <= state_d == LOCKED;
            lost_q <= state_d == LOST;
        end
    end
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign locked = locked_q;
    assign lost = lost_q;
`ifdef ICLK_MON_PERIOD_OUT_EN
    assign period_meas = sample_q;
`endif
endmodule

// File: tb/tb_iclk_monitor.sv
// tb_iclk_monitor: table-driven, hand-written and random period sequences against a timestamp-based reference model
module tb_iclk_monitor;
    localparam int S = 2, EXP = 25, TOL = 2, LC = 4, TMO = 64, MAXC = 16384;
    logic clk100mhz = 1'b0, rst = 1'b1, iclk_in = 1'b0, lost_clr = 1'b0;
    logic rise_stb, fall_stb, locked, lost;
`ifdef ICLK_MON_PERIOD_OUT_EN
    logic [6:0] period_meas;
`endif
    iclk_monitor dut (
        .clk100mhz(clk100mhz),
        .rst(rst),
        .iclk_in(iclk_in),
        .lost_clr(lost_clr),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb),
        .locked(locked),
`ifdef ICLK_MON_PERIOD_OUT_EN
        .period_meas(period_meas),
`endif
        .lost(lost)
    );
    always #5 clk100mhz = ~clk100mhz;
    typedef struct {
        int hi;
        int lo;
        int clr_at;
        int rst_at;
        bit exp_locked;
        bit exp_lost;
    } row_t;
    row_t tbl[39];
    bit hist[MAXC], clr_h[MAXC], rst_h[MAXC];
    int cyc, n_cmp, n_bad;
    int m_mode, m_good, m_last;
    bit m_rise, m_fall;
    bit s_rise, s_fall, s_locked, s_lost;
    function automatic bit h(input int i);
        return (i >= 0) ? hist[i] : 1'b0;
    endfunction
    // One clk100mhz cycle: drive inputs, advance the model from last cycle's events, compare all outputs
    task automatic step(input bit v, input bit c, input bit r);
        bit pr;
        int per;
        logic [3:0] exp_v, got;
        iclk_in = v;
        lost_clr = c;
        rst = r;
        hist[cyc] = v;
        clr_h[cyc] = c;
        rst_h[cyc] = r;
        @(negedge clk100mhz);
        pr = m_rise;
        if (rst_h[cyc-1]) begin
            m_mode = 0;
            m_good = 0;
            m_last = -1;
        end else begin
            per = (cyc - 1) - m_last;
            if (per > TMO) per = TMO;
            if ((m_mode == 1 || m_mode == 2) && !pr && cyc - m_last + 1 >= TMO) m_mode = 3;
            else if (m_mode == 0 && pr) begin
                m_mode = 1;
                m_good = 0;
            end else if (m_mode == 1 && pr) begin
                m_good = (per >= EXP - TOL && per <= EXP + TOL) ? m_good + 1 : 0;
                if (m_good == LC) m_mode = 2;
            end else if (m_mode == 2 && pr && !(per >= EXP - TOL && per <= EXP + TOL)) m_mode = 3;
            else if (m_mode == 3 && clr_h[cyc-1]) m_mode = 0;
            if (pr) m_last = cyc - 1;
        end
        m_rise = !rst_h[cyc-1] && h(cyc - S - 1) && !h(cyc - S - 2);
        m_fall = !rst_h[cyc-1] && !h(cyc - S - 1) && h(cyc - S - 2);
        exp_v = {m_rise, m_fall, m_mode == 2, m_mode == 3};
        got = {rise_stb, fall_stb, locked, lost};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL outs cyc=%0d {rise,fall,locked,lost} got=%b exp=%b", cyc, got, exp_v);
        end
        s_rise = rise_stb;
        s_fall = fall_stb;
        s_locked = locked;
        s_lost = lost;
        @(posedge clk100mhz);
        #1;
        cyc++;
    endtask
    task automatic run_row(input int hi, input int lo, input int ca, input int ra);
        for (int k = 0; k < hi + lo; k++) step(k < hi, k == ca, k == ra);
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_mode = 0;
        m_good = 0;
        m_last = -1;
        m_rise = 1'b0;
        m_fall = 1'b0;
        for (int i = 0; i < 39; i++) tbl[i] = '{12, 13, -1, -1, 1'b0, 1'b0};
        foreach (tbl[i]) if (i inside {4, 5, 11, 21, 22, 23, 24, 25, 32, 38}) tbl[i].exp_locked = 1'b1;
        foreach (tbl[i]) if (i inside {6, 12, 13, 26}) tbl[i].exp_lost = 1'b1;
        tbl[5].lo = 17;
        tbl[7].clr_at = 0;
        tbl[12].lo = 80;
        tbl[14].clr_at = 0;
        tbl[16].lo = 18;
        tbl[22].lo = 15;
        tbl[22].clr_at = 0;
        tbl[23].lo = 11;
        tbl[25].hi = 11;
        tbl[25].lo = 11;
        tbl[27].clr_at = 3;
        tbl[33].rst_at = 18;
        rst_h[0] = 1'b1;
        @(posedge clk100mhz);
        #1;
        cyc = 1;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) begin
            run_row(tbl[i].hi, tbl[i].lo, tbl[i].clr_at, tbl[i].rst_at);
            n_cmp++;
            if ({s_locked, s_lost} !== {tbl[i].exp_locked, tbl[i].exp_lost}) begin
                n_bad++;
                $display("FAIL row%0d {locked,lost} got=%b%b exp=%b%b", i, s_locked, s_lost, tbl[i].exp_locked, tbl[i].exp_lost);
            end
`ifdef ICLK_MON_PERIOD_OUT_EN
            if (i == 6) begin
                n_cmp++;
                if (period_meas !== 7'd29) begin
                    n_bad++;
                    $display("FAIL period_meas got=%0d exp=29", period_meas);
                end
            end
`endif
        end
        for (int i = 0; i < 150; i++) begin
            int p, hi, ca, ra;
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 90) : $urandom_range(21, 29);
            hi = $urandom_range(1, p - 1);
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, p - 1) : -1;
            ra = (p - hi >= 8 && $urandom_range(0, 24) == 0) ? hi + 5 : -1;
            run_row(hi, p - hi, ca, ra);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (s_rise !== (k == 3)) begin
                n_bad++;
                $display("FAIL rise_lat offset=%0d got=%b exp=%b", k, s_rise, k == 3);
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (s_fall !== (k == 3)) begin
                n_bad++;
                $display("FAIL fall_lat offset=%0d got=%b exp=%b", k, s_fall, k == 3);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iclk_monitor.md
ICLK_MONITOR -- requirements
Module: iclk_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for iclk_in (legal 2..4).
REQ-002 Parameter EXP_PERIOD, default 25, sets the expected iclk_in period in clk100mhz cycles.
REQ-003 Parameter TOL, default 2, sets the allowed period deviation of ±TOL cycles.
REQ-004 Parameter LOCK_COUNT, default 4, sets the number of consecutive in-tolerance periods required to lock.
REQ-005 Parameter TIMEOUT, default 64, sets the number of cycles without a rising edge that declares the clock lost (must be > EXP_PERIOD+TOL, ≤ 127).
REQ-006 clk100mhz  in  1  the single system clock; all logic is on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 iclk_in  in  1  the monitored divided clock (~4 MHz), asynchronous to clk100mhz.
REQ-009 lost_clr  in  1  single-cycle request to clear the sticky lost condition.
REQ-010 rise_stb  out  1  one-cycle pulse per detected iclk_in rising edge.
REQ-011 fall_stb  out  1  one-cycle pulse per detected iclk_in falling edge.
REQ-012 locked  out  1  high while in state LOCKED.
REQ-013 lost  out  1  high while in state LOST.

Function
REQ-014 iclk_in shall pass through a SYNC_STAGES flop chain; the last stage is compared to a one-cycle-delayed copy for edge detection.
REQ-015 rise_stb/fall_stb shall be registered; each is high exactly one cycle, SYNC_STAGES+1 clk100mhz edges after the first edge that samples the new iclk_in level.
REQ-016 A 7-bit period counter shall load 1 on the cycle rise_stb is high, otherwise increment, saturating at TIMEOUT.
REQ-017 A period sample shall be the counter value in the cycle before a rise_stb; it is in tolerance iff EXP_PERIOD-TOL ≤ sample ≤ EXP_PERIOD+TOL.
REQ-018 The FSM shall have states IDLE, ACQ, LOCKED and LOST, and shall enter IDLE on reset.
REQ-019 IDLE: on the first rise_stb, go to ACQ with good_cnt=0; a sample is not evaluated on this edge.
REQ-020 ACQ: on each rise_stb, an in-tolerance sample increments good_cnt and an out-of-tolerance sample clears it; when good_cnt reaches LOCK_COUNT, go to LOCKED.
REQ-021 LOCKED: an out-of-tolerance sample on rise_stb shall go to LOST in the next cycle.
REQ-022 ACQ or LOCKED: the period counter reaching TIMEOUT shall go to LOST.
REQ-023 IDLE never times out; a stuck input after reset leaves locked=0 and lost=0.
REQ-024 LOST is sticky; edges are ignored there, and only lost_clr (→IDLE) or rst leaves it.
REQ-025 lost_clr outside LOST shall have no effect; lost_clr and rise_stb in the same cycle in LOST shall go to IDLE and discard that edge.
REQ-026 locked and lost shall be registered FSM decodes and shall never be high simultaneously.

Reset
REQ-027 When rst is high at a clk100mhz edge, the synchronizer, the edge-detect register, the period counter (0), good_cnt (0) and the FSM (IDLE) shall all clear, and rise_stb, fall_stb, locked and lost shall be 0 in the next cycle.
REQ-028 rst asserted mid-measurement shall discard any partial period; the first rise_stb after release is treated as the IDLE first edge.

Configuration
REQ-029 With macro ICLK_MON_PERIOD_OUT_EN defined, an added output period_meas [6:0] shall hold the last period sample, updated on each rise_stb and reset to 0.
REQ-030 Without ICLK_MON_PERIOD_OUT_EN, period_meas shall not exist, and all other behaviour shall be identical.

Verification
REQ-031 Default parameters, iclk_in with a 25-cycle period (12 cycles high / 13 low) → rise_stb once per 25 cycles, locked=1 after the 5th rise_stb, lost=0.
REQ-032 Locked, then one period stretched to 29 cycles → lost=1 the cycle after that rise_stb, locked=0; with the macro defined, period_meas=29.
REQ-033 Locked, then iclk_in held low → lost=1 when the counter reaches 64; a lost_clr pulse → IDLE and lost=0; a 25-cycle clock resumes → relock after 5 edges.
REQ-034 Acquiring, with periods 25,25,30,25,25,25,25 → good_cnt reset by the 30, locked asserted only after the 4th consecutive 25.
REQ-035 rst pulsed mid-period while locked → all outputs 0 the next cycle; lock is regained after 5 rising edges.
REQ-036 Single iclk_in transition → rise_stb or fall_stb is exactly one cycle wide, with fixed latency SYNC_STAGES+1.
